// File: rtl/cache_mem_arbiter.sv
// Single-port physical-memory arbiter for the I-cache and D-cache line paths.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: D over I).
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              d_req_s;
    logic              grant_d_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d_q, last_d_d;
`endif

    // Arbitration: decide whether the D-cache wins an IDLE-cycle grant.
    always_comb begin
        d_req_s = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d_s = d_req_s & (~i_read | ~last_d_q);
`else
        grant_d_s = d_req_s;
`endif
    end

    // Next-state, latch updates and same-cycle response outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d_s) begin
                    state_d = SERVE_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    // A simultaneous read+write is the writeback ahead of a refill.
                    wr_d    = d_write;
                    rd_d    = ~d_write;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_read) begin
                    state_d = SERVE_I;
                    addr_d  = i_addr;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = pmem_rdata;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = pmem_rdata;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = SERVE_D;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and transaction latches; strobes come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    assign pmem_read  = rd_q;
    assign pmem_write = wr_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;

endmodule
